// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port arbiter for single-port sync-read data memory; builds
//            byte-write masks and returns tagged read data one cycle later.
//            Define DMEM_ARB_RR_EN for round-robin instead of fixed priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [31:0]       addr0,
    input  logic [1:0]        size0,
    input  logic [31:0]       wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [31:0]       rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [31:0]       addr1,
    input  logic [1:0]        size1,
    input  logic [31:0]       wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [31:0]       rdata1,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output logic              misalign_err
);

    localparam logic [7:0] C_MAX_WAIT = 8'(MAX_WAIT);

    logic [7:0]  r_wait_cnt;
    logic        r_rvalid;
    logic        r_tag;
    logic        r_mis;

    logic        w_pref1;
    logic        w_en;
    logic        w_we;
    logic [31:0] w_addr;
    logic [1:0]  w_size;
    logic [31:0] w_wdata;
    logic [1:0]  w_off;
    logic [3:0]  w_mask;
    logic [31:0] w_din;
    logic        w_mis;
    logic        w_unused_addr;

`ifdef DMEM_ARB_RR_EN
    logic r_last;   // last port granted; reset to 1 so port 0 wins first contention

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_en) begin
            r_last <= gnt1;
        end
    end

    assign w_pref1 = ~r_last | (r_wait_cnt == C_MAX_WAIT);
`else
    assign w_pref1 = (r_wait_cnt == C_MAX_WAIT);
`endif

    assign gnt0 = rst_n & req0 & ~(req1 & w_pref1);
    assign gnt1 = rst_n & req1 & ~(req0 & ~w_pref1);
    assign w_en = gnt0 | gnt1;

    assign w_we    = gnt1 ? we1    : we0;
    assign w_addr  = gnt1 ? addr1  : addr0;
    assign w_size  = gnt1 ? size1  : size0;
    assign w_wdata = gnt1 ? wdata1 : wdata0;
    assign w_off   = w_addr[1:0];
    assign w_unused_addr = ^w_addr[31:ADDR_W+2];

    always_comb begin
        w_mask = 4'b1111;
        w_din  = w_wdata;
        w_mis  = 1'b0;
        case (w_size)
            2'b00: begin
                w_mask = 4'b0001 << w_off;
                w_din  = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_mask = 4'b0011 << {w_off[1], 1'b0};
                w_din  = {2{w_wdata[15:0]}};
                w_mis  = w_off[0];
            end
            default: begin
                w_mis  = (w_off != 2'b00);
            end
        endcase
    end

    // Misaligned writes still consume the grant but touch no bytes
    assign mem_en   = w_en;
    assign mem_we   = (w_en && w_we && !w_mis) ? w_mask : 4'b0000;
    assign mem_addr = w_addr[ADDR_W+1:2];
    assign mem_din  = w_din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 8'd0;
            r_rvalid   <= 1'b0;
            r_tag      <= 1'b0;
            r_mis      <= 1'b0;
        end else begin
            r_wait_cnt <= (req1 && !gnt1) ? r_wait_cnt + 8'd1 : 8'd0;
            r_rvalid   <= w_en & ~w_we;
            r_tag      <= gnt1;
            r_mis      <= w_en & w_we & w_mis;
        end
    end

    assign rvalid0      = r_rvalid & ~r_tag;
    assign rvalid1      = r_rvalid & r_tag;
    assign rdata0       = mem_dout;
    assign rdata1       = mem_dout;
    assign misalign_err = r_mis;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed + randomized self-checking bench for dmem_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int ADDR_W   = 14;
    localparam int MAX_WAIT = 3;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req0, we0, req1, we1;
    logic [31:0]       addr0, wdata0, addr1, wdata1;
    logic [1:0]        size0, size1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0]       rdata0, rdata1;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;
    logic              misalign_err;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] dev_mem [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .size0(size0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .size1(size1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .misalign_err(misalign_err)
    );

    // Synchronous-read single-port memory, read-before-write
    always @(posedge clk) begin
        if (mem_en) begin
            mem_dout <= dev_mem[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) dev_mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    int          m_deny = 0;
    bit          m_last = 1'b1;
    bit          m_pv = 1'b0, m_pport = 1'b0, m_perr = 1'b0;
    logic [31:0] m_pdata = '0;

    always @(negedge clk) begin
        int          win;
        bit          w;
        logic [31:0] a, d;
        logic [1:0]  s;
        logic [3:0]  ewe;
        logic [31:0] edin;
        bit          mis;
        int          idx;
        if (!rst_n) begin
            chk("rst_gnt0", 32'(gnt0), 0);
            chk("rst_gnt1", 32'(gnt1), 0);
            chk("rst_mem_en", 32'(mem_en), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_rvalid0", 32'(rvalid0), 0);
            chk("rst_rvalid1", 32'(rvalid1), 0);
            chk("rst_misalign", 32'(misalign_err), 0);
            m_deny = 0; m_last = 1'b1; m_pv = 1'b0; m_perr = 1'b0;
        end else begin
            chk("rvalid0", 32'(rvalid0), 32'(m_pv && !m_pport));
            chk("rvalid1", 32'(rvalid1), 32'(m_pv && m_pport));
            if (m_pv) begin
                chk("rdata0", rdata0, m_pdata);
                chk("rdata1", rdata1, m_pdata);
            end
            chk("misalign_err", 32'(misalign_err), 32'(m_perr));

            win = -1;
            if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
                win = (m_deny == MAX_WAIT || m_last == 1'b0) ? 1 : 0;
`else
                win = (m_deny == MAX_WAIT) ? 1 : 0;
`endif
            end else if (req0) win = 0;
            else if (req1) win = 1;

            chk("gnt0", 32'(gnt0), 32'(win == 0));
            chk("gnt1", 32'(gnt1), 32'(win == 1));
            chk("mem_en", 32'(mem_en), 32'(win >= 0));

            w = (win == 1) ? we1 : we0;
            a = (win == 1) ? addr1 : addr0;
            s = (win == 1) ? size1 : size0;
            d = (win == 1) ? wdata1 : wdata0;
            case (s)
                2'd0: begin ewe = 4'(1 << a[1:0]); edin = {4{d[7:0]}}; mis = 0; end
                2'd1: begin mis = a[0]; ewe = a[1] ? 4'b1100 : 4'b0011; edin = {2{d[15:0]}}; end
                default: begin mis = (a[1:0] != 0); ewe = 4'hF; edin = d; end
            endcase
            if (mis || !w || win < 0) ewe = 4'b0000;
            idx = int'(a[ADDR_W+1:2]);

            chk("mem_we", 32'(mem_we), 32'(ewe));
            if (win >= 0) chk("mem_addr", 32'(mem_addr), 32'(idx));
            if (win >= 0 && w) chk("mem_din", mem_din, edin);

            m_pv    = (win >= 0) && !w;
            m_pport = (win == 1);
            m_perr  = (win >= 0) && w && mis;
            if (win >= 0) m_pdata = ref_mem[idx];
            for (int b = 0; b < 4; b++)
                if (ewe[b]) ref_mem[idx][8*b +: 8] = edin[8*b +: 8];
            m_deny = (req1 && win != 1) ? m_deny + 1 : 0;
            if (win >= 0) m_last = (win == 1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set0(input logic r, input logic w, input logic [31:0] a,
                        input logic [1:0] s, input logic [31:0] d);
        req0 = r; we0 = w; addr0 = a; size0 = s; wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic [31:0] a,
                        input logic [1:0] s, input logic [31:0] d);
        req1 = r; we1 = w; addr1 = a; size1 = s; wdata1 = d;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit exp1;
        for (int i = 0; i < DEPTH; i++) begin
            dev_mem[i] = 32'(i) * 32'h9E37_79B9;
            ref_mem[i] = dev_mem[i];
        end
        set0(1, 0, 32'h0, 2'd2, 32'h0);
        set1(1, 0, 32'h4, 2'd2, 32'h0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("L_reset_gnt0", 32'(gnt0), 0);
        chk("L_reset_mem_en", 32'(mem_en), 0);

        // Byte write 0xAB to 0x1000_0006
        nxt(); rst_n = 1'b1;
        set1(0, 0, 32'h0, 2'd0, 32'h0);
        set0(1, 1, 32'h1000_0006, 2'd0, 32'h0000_00AB);
        @(negedge clk);
        chk("L_byte_gnt0", 32'(gnt0), 1);
        chk("L_byte_we", 32'(mem_we), 32'h4);
        chk("L_byte_din", mem_din, 32'hABAB_ABAB);
        chk("L_byte_addr", 32'(mem_addr), 32'h1);
        nxt(); set0(0, 0, 32'h0, 2'd0, 32'h0);
        @(negedge clk);
        chk("L_byte_no_rvalid", 32'(rvalid0), 0);

        // Read then immediate write on the other port
        nxt(); set0(1, 1, 32'h40, 2'd2, 32'hDEAD_BEEF);
        nxt(); set0(1, 0, 32'h40, 2'd2, 32'h0);
        nxt(); set0(0, 0, 32'h0, 2'd0, 32'h0); set1(1, 1, 32'h40, 2'd2, 32'h1234_5678);
        @(negedge clk);
        chk("L_rw_gnt1", 32'(gnt1), 1);
        chk("L_rw_rvalid0", 32'(rvalid0), 1);
        chk("L_rw_rdata0", rdata0, 32'hDEAD_BEEF);
        nxt(); set1(0, 0, 32'h0, 2'd0, 32'h0); set0(1, 0, 32'h40, 2'd2, 32'h0);
        nxt(); set0(0, 0, 32'h0, 2'd0, 32'h0);
        @(negedge clk);
        chk("L_rw_readback", rdata0, 32'h1234_5678);

        // Misaligned half write from port 1
        nxt(); set0(1, 1, 32'h0, 2'd2, 32'h1122_3344);
        nxt(); set0(0, 0, 32'h0, 2'd0, 32'h0); set1(1, 1, 32'h3, 2'd1, 32'h0000_BEEF);
        @(negedge clk);
        chk("L_mis_we", 32'(mem_we), 0);
        chk("L_mis_gnt1", 32'(gnt1), 1);
        nxt(); set1(0, 0, 32'h0, 2'd0, 32'h0);
        @(negedge clk);
        chk("L_mis_err", 32'(misalign_err), 1);
        nxt(); set0(1, 0, 32'h0, 2'd2, 32'h0);
        @(negedge clk);
        chk("L_mis_err_off", 32'(misalign_err), 0);
        nxt(); set0(0, 0, 32'h0, 2'd0, 32'h0);
        @(negedge clk);
        chk("L_mis_readback", rdata0, 32'h1122_3344);

        // Reset pulsed after a granted read
        nxt(); set0(1, 0, 32'h40, 2'd2, 32'h0);
        @(negedge clk);
        chk("L_rst_read_gnt0", 32'(gnt0), 1);
        nxt(); set0(0, 0, 32'h0, 2'd0, 32'h0); rst_n = 1'b0;
        @(negedge clk);
        chk("L_rst_drop_rvalid", 32'(rvalid0), 0);
        nxt(); rst_n = 1'b1;
        @(negedge clk);
        chk("L_rst_no_replay", 32'(rvalid0), 0);

        // Continuous contention from reset
        for (int i = 0; i < 8; i++) begin
            nxt();
            set0(1, 0, 32'(i * 4), 2'd2, 32'h0);
            set1(1, 0, 32'(32'h80 + i * 4), 2'd2, 32'h0);
            @(negedge clk);
`ifdef DMEM_ARB_RR_EN
            exp1 = (i % 2 == 1);
`else
            exp1 = (i % 4 == 3);
`endif
            chk("L_contend_gnt1", 32'(gnt1), 32'(exp1));
            chk("L_contend_gnt0", 32'(gnt0), 32'(!exp1));
        end

        // Randomized traffic, with occasional reset pulses
        for (int n = 0; n < 3000; n++) begin
            nxt();
            rst_n = ($urandom_range(0, 199) != 0);
            set0($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 $urandom & 32'hFFFF_007F, 2'($urandom_range(0, 3)), $urandom);
            set1($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 $urandom & 32'hFFFF_007F, 2'($urandom_range(0, 3)), $urandom);
        end
        nxt();
        rst_n = 1'b1;
        set0(0, 0, 32'h0, 2'd0, 32'h0);
        set1(0, 0, 32'h0, 2'd0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, synchronous-read data memory between two requesters: port 0 (CPU load/store stage) and port 1 (UART program loader / debug DMA).
- Arbitrates each cycle and builds the memory byte-write mask from access size and address offset.
- Returns read data one cycle after grant, tagged to the winning port.
- Sits between the CPU memory stage and the dmem block; load-data extraction and sign extension stay downstream in the CPU.

Parameters:
- ADDR_W, 14, dmem word-address width. The memory word address is addr[ADDR_W+1:2].
- MAX_WAIT, 8, number of consecutive cycles port 1 may be denied before it is force-granted. Legal range is 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  32  port 0 byte address.
- size0  in  2  port 0 size: 00 byte, 01 half, 10 word (funct3[1:0]).
- wdata0  in  32  port 0 store data, right-aligned.
- gnt0  out  1  port 0 granted this cycle; combinational.
- rvalid0  out  1  port 0 read data valid; registered.
- rdata0  out  32  port 0 read data, raw word.
- req1, we1, addr1, size1, wdata1, gnt1, rvalid1, rdata1: identical set for port 1.
- mem_en  out  1  memory enable.
- mem_we  out  4  byte write enables.
- mem_addr  out  ADDR_W  memory word address.
- mem_din  out  32  memory write data.
- mem_dout  in  32  memory read data, valid the cycle after mem_en.
- misalign_err  out  1  one-cycle pulse for a granted misaligned write; registered.

Behaviour:
- Grant logic:
  - A transfer occurs when reqN && gntN.
  - At most one of gnt0/gnt1 is high in any cycle; neither is high when no request is present.
  - The winner drives mem_en=1, mem_addr and mem_din in the same cycle.
- Default policy (fixed priority): port 0 wins when both ports request.
- Starvation counter wait_cnt (8 bits):
  - Increments each cycle req1 is high and gnt1 is low.
  - Clears when gnt1 is high or req1 is low.
  - When wait_cnt == MAX_WAIT, port 1 wins over port 0 in that cycle.
- Write mask:
  - Byte: mem_we = 0001 << addr[1:0]; mem_din = byte replicated x4.
  - Half: mem_we = 0011 << {addr[1],1'b0}; mem_din = half replicated x2.
  - Word: mem_we = 1111; mem_din = wdata.
  - size=11 is treated as word.
- Misaligned write (half with addr[0]=1, or word with addr[1:0]!=0):
  - The write is granted but mem_we=0000, so memory is unchanged.
  - misalign_err pulses high the following cycle.
- Reads: mem_we=0000. Misaligned reads are not flagged; the raw word is returned.
- Read return:
  - A registered 1-bit valid plus port tag captures each granted read.
  - The next cycle, rvalidN=1 for the tagged port and rdataN=mem_dout.
  - The untagged port sees rvalid=0. rdata0 and rdata1 both carry mem_dout at all times.
- Back-to-back grants are legal every cycle, including read on one port immediately followed by write on the other. There are no bubbles.
- Reset values:
  - gnt0 = gnt1 = 0 while rst_n is low.
  - rvalid0 = rvalid1 = 0, misalign_err = 0, wait_cnt = 0, priority pointer = port 0.
  - mem_en = 0 and mem_we = 0 while in reset.
- Reset asserted mid-read: the pending rvalid is dropped and is not replayed after reset.

Optional Feature:
- DMEM_ARB_RR_EN defined:
  - Fair round-robin replaces fixed priority.
  - A 1-bit last-winner register is updated on every grant. On contention, the port that did not win last is granted.
  - Reset value of last-winner is port 1, so port 0 wins the first contention.
  - The starvation counter is still present but can never reach MAX_WAIT > 1.
- DMEM_ARB_RR_EN undefined: fixed port-0 priority with starvation override, as described in Behaviour.

Test Plan:
- Port 0 only, byte write of 0xAB to addr 0x1000_0006 -> gnt0=1, mem_we=0100, mem_din=0xABABABAB, mem_addr=0x001; rvalid0 stays 0.
- Both ports request reads every cycle, MAX_WAIT=3, RR off -> port 0 granted cycles 0-2, port 1 granted cycle 3, pattern repeats. rvalid tags follow one cycle later with the correct port.
- Same stimulus with DMEM_ARB_RR_EN -> grants alternate 0,1,0,1…, starting with port 0.
- Port 1 half write to addr 0x3 -> mem_we=0000, misalign_err=1 the next cycle for exactly one cycle; memory unchanged on readback.
- Port 0 read of a word holding 0xDEADBEEF, followed immediately by a port 1 word write of 0x12345678 to the same address -> rvalid0=1, rdata0=0xDEADBEEF; a later read returns 0x12345678.
- rst_n pulsed low the cycle after a granted read -> rvalid0 never asserts; all outputs 0 during reset; the first post-reset contention goes to port 0.
